// File: rtl/mat_engine_arbiter_pkg.sv
// Shared definitions for the matrix-engine arbiter: FSM encoding, result width
// and the default watchdog limit.
package mat_engine_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LAUNCH  = 2'b01,
        WAIT    = 2'b10,
        RESPOND = 2'b11
    } state_t;

    localparam int RES_W                  = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting index after last_grant, wrapping mod NREQ.
module rr_pick
    import mat_engine_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);

    int               idx;
    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant     = '0;
        any_valid = |req;
        idx       = 0;
        cand      = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx  = (int'(last_grant) + i) % NREQ;
            cand = IDX_W'(idx);
            if (req[cand]) begin
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/mat_engine_arbiter.sv
// Arbitrates NREQ requesters onto one shared 2x2 matrix engine, one job at a time.
// Optional engine watchdog enabled by defining MAT_ARB_TIMEOUT_EN.
module mat_engine_arbiter
    import mat_engine_arbiter_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*4*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [RES_W-1:0]        resp_data,
    output logic                    resp_err,
    output logic [4*WIDTH-1:0]      eng_a,
    output logic                    eng_start,
    input  logic                    eng_done,
    output logic                    eng_done_ack,
    input  logic [RES_W-1:0]        eng_res,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int OP_W  = 4 * WIDTH;

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_pick;
    logic [IDX_W-1:0] last_grant;
    logic             any_valid;
    logic [OP_W-1:0]  operand;
    logic [RES_W-1:0] result;
    logic             accept;
    logic             take_result;
    logic             take_timeout;
    logic             release_job;
    logic             timeout_hit;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant_pick),
        .any_valid  (any_valid)
    );

    // Handshake outputs are gated by reset so an in-flight job cannot be acknowledged
    // or answered during the reset cycle.
    always_comb begin
        state_d      = state;
        req_ready    = '0;
        resp_valid   = '0;
        eng_start    = 1'b0;
        eng_done_ack = 1'b0;
        accept       = 1'b0;
        take_result  = 1'b0;
        take_timeout = 1'b0;
        release_job  = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        accept                = 1'b1;
                        req_ready[grant_pick] = 1'b1;
                        state_d               = LAUNCH;
                    end
                end
                LAUNCH: begin
                    eng_start = 1'b1;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        eng_done_ack = 1'b1;
                        take_result  = 1'b1;
                        state_d      = RESPOND;
                    end else if (timeout_hit) begin
                        take_timeout = 1'b1;
                        state_d      = RESPOND;
                    end
                end
                RESPOND: begin
                    resp_valid[grant] = 1'b1;
                    if (resp_ready[grant]) begin
                        release_job = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NREQ - 1);
            operand    <= '0;
            result     <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                grant   <= grant_pick;
                operand <= req_data[int'(grant_pick) * OP_W +: OP_W];
            end
            if (take_result) begin
                result <= eng_res;
            end else if (take_timeout) begin
                result <= '0;
            end
            if (release_job) begin
                last_grant <= grant;
            end
        end
    end

`ifdef MAT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] watchdog;
    logic            err_flag;

    // Counter is zeroed in LAUNCH so it always starts fresh on WAIT entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            watchdog <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                watchdog <= '0;
            end else if (state == WAIT && !eng_done) begin
                watchdog <= watchdog + 1'b1;
            end
            if (take_result) begin
                err_flag <= 1'b0;
            end else if (take_timeout) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign timeout_hit = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign resp_err    = err_flag;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign resp_err       = 1'b0;
`endif

    assign resp_data = result;
    assign eng_a     = operand;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mat_engine_arbiter.sv
// Directed scoreboard bench for mat_engine_arbiter (NREQ=4, WIDTH=8).
module tb_mat_engine_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int OP_W  = 4 * WIDTH;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*OP_W-1:0]    req_data;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         resp_valid;
    logic [NREQ-1:0]         resp_ready;
    logic [63:0]             resp_data;
    logic                    resp_err;
    logic [OP_W-1:0]         eng_a;
    logic                    eng_start;
    logic                    eng_done;
    logic                    eng_done_ack;
    logic [63:0]             eng_res;
    logic                    busy;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    mat_engine_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .eng_a        (eng_a),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_done_ack (eng_done_ack),
        .eng_res      (eng_res),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(1) << e.idx);
            chk({tag, "_resp_data"}, resp_data, e.data);
            chk({tag, "_resp_err"}, 64'(resp_err), 64'(e.err));
        end
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        chk({tag, "_eng_done_ack"}, 64'(eng_done_ack), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        chk({tag, "_resp_data"}, resp_data, 64'd0);
        chk({tag, "_eng_a"}, 64'(eng_a), 64'd0);
    endtask

    // Called at a negedge in IDLE with req_valid driven; leaves the DUT in WAIT
    // (first WAIT cycle begins at the next posedge).
    task automatic accept_launch(input int g, input logic drop, output logic [OP_W-1:0] op);
        #1;
        chk($sformatf("accept%0d_req_ready", g), 64'(req_ready), 64'(1) << g);
        op = req_data[g*OP_W +: OP_W];
        @(negedge clk);
        if (drop) req_valid[g] = 1'b0;
        #1;
        chk($sformatf("launch%0d_eng_start", g), 64'(eng_start), 64'd1);
        chk($sformatf("launch%0d_eng_a", g), 64'(eng_a), 64'(op));
        chk($sformatf("launch%0d_req_ready", g), 64'(req_ready), 64'd0);
        chk($sformatf("launch%0d_busy", g), 64'(busy), 64'd1);
    endtask

    task automatic run_job(input int g, input logic [63:0] res, input int wait_n,
                           input int hold_n, input logic drop);
        logic [OP_W-1:0] op;
        exp_t e;
        accept_launch(g, drop, op);
        e.idx = 32'(g); e.data = res; e.err = 1'b0;
        sb.push_back(e);
        repeat (wait_n) begin
            @(negedge clk); #1;
            chk($sformatf("wait%0d_eng_start", g), 64'(eng_start), 64'd0);
            chk($sformatf("wait%0d_no_ack", g), 64'(eng_done_ack), 64'd0);
            chk($sformatf("wait%0d_no_resp", g), 64'(resp_valid), 64'd0);
        end
        @(negedge clk);
        eng_done = 1'b1; eng_res = res; #1;
        chk($sformatf("done%0d_ack", g), 64'(eng_done_ack), 64'd1);
        @(negedge clk);
        eng_done = 1'b0; eng_res = {$urandom, $urandom}; #1;
        chk($sformatf("respond%0d_no_ack", g), 64'(eng_done_ack), 64'd0);
        chk($sformatf("respond%0d_eng_a", g), 64'(eng_a), 64'(op));
        repeat (hold_n) begin
            chk($sformatf("hold%0d_resp_valid", g), 64'(resp_valid), 64'(1) << g);
            chk($sformatf("hold%0d_resp_data", g), resp_data, res);
            @(negedge clk); #1;
        end
        resp_ready = 4'(1 << g); #1;
        sb_check($sformatf("job%0d", g));
        @(negedge clk);
        resp_ready = '0;
    endtask

    initial begin
        logic [OP_W-1:0] op;
        exp_t            e;

        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = '0;
        eng_done   = 1'b0;
        eng_res    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1; #1;
        reset_outputs("after_reset");

        // Basic job from 0101: requester 0 first, then requester 2.
        @(negedge clk);
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0101;
        run_job(0, 64'h11223344, 0, 0, 1'b1);
        run_job(2, {$urandom, $urandom}, 1, 0, 1'b1);

        // Late done and a stalled consumer.
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b1000;
        run_job(3, {$urandom, $urandom}, 12, 5, 1'b1);

        // All four requesting continuously: rotation 0,1,2,3,0.
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            run_job(k % 4, {$urandom, $urandom}, k % 3, 0, 1'b0);
        end
        req_valid = '0;

        // Engine never finishes.
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0010;
        accept_launch(1, 1'b1, op);
        repeat (64) begin
            @(negedge clk); #1;
            chk("stall_no_resp", 64'(resp_valid), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
        end
        @(negedge clk); #1;
`ifdef MAT_ARB_TIMEOUT_EN
        e.idx = 32'd1; e.data = 64'd0; e.err = 1'b1;
        sb.push_back(e);
        resp_ready = 4'b0010; #1;
        sb_check("timeout");
        @(negedge clk);
        resp_ready = '0;
        req_valid  = 4'b0100;
        accept_launch(2, 1'b1, op);
        @(negedge clk); #1;
`else
        chk("no_timeout_resp", 64'(resp_valid), 64'd0);
        chk("no_timeout_busy", 64'(busy), 64'd1);
`endif

        // Reset while WAITing, with eng_done arriving in the same cycle.
        reset    = 1'b0;
        eng_done = 1'b1; #1;
        chk("reset_wait_no_ack", 64'(eng_done_ack), 64'd0);
        chk("reset_wait_no_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        eng_done = 1'b0; #1;
        reset_outputs("mid_reset");
        repeat (2) begin
            @(negedge clk); #1;
            chk("post_reset_idle", 64'(busy), 64'd0);
        end

        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b1000;
        run_job(3, {$urandom, $urandom}, 2, 1, 1'b1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_engine_arbiter.md
MAT_ENGINE_ARBITER -- requirements
Module: mat_engine_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 8, operand element width.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, engine watchdog limit.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-low reset.
- req_valid, in, NREQ, per-requester job request.
- req_data, in, NREQ*4*WIDTH, packed 2x2 operand per requester; slice g = bits [(g+1)*4*WIDTH-1 : g*4*WIDTH].
- req_ready, out, NREQ, one-hot job-accept pulse.
- resp_valid, out, NREQ, one-hot result valid.
- resp_ready, in, NREQ, per-requester result accept.
- resp_data, out, 64, result of the granted job.
- resp_err, out, 1, result is a timeout error.
- eng_a, out, 4*WIDTH, operand to engine.
- eng_start, out, 1, engine start pulse.
- eng_done, in, 1, engine done level.
- eng_done_ack, out, 1, engine done acknowledge.
- eng_res, in, 64, engine result.
- busy, out, 1, state not IDLE.
REQ-003 Clock SHALL be clk; reset SHALL be reset, synchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, LAUNCH, WAIT, RESPOND.
REQ-005 IDLE: if any req_valid is set, grant g = first set bit searching round-robin from last_grant+1 (mod NREQ); same cycle drive req_ready[g]=1, latch req_data slice g into operand register, latch g; next state LAUNCH.
REQ-006 req_ready SHALL be high for exactly one cycle per accepted job and zero in all other states.
REQ-007 LAUNCH: eng_start=1 for exactly one cycle; next state WAIT.
REQ-008 eng_a SHALL equal the operand register continuously and SHALL change only at acceptance in IDLE.
REQ-009 WAIT: when eng_done=1, drive eng_done_ack=1 in that cycle, latch eng_res into result register, clear resp_err; next state RESPOND.
REQ-010 eng_done_ack SHALL be zero outside the WAIT-with-eng_done cycle.
REQ-011 RESPOND: resp_valid[g]=1, resp_data = result register; hold until resp_ready[g]=1; then set last_grant=g, next state IDLE.
REQ-012 Requests arriving outside IDLE SHALL be ignored; a requester keeps req_valid high until req_ready.
REQ-013 Minimum turnaround SHALL be: accept (IDLE), LAUNCH, WAIT >= 1 cycle, RESPOND >= 1 cycle, i.e. a new accept no earlier than 4 cycles after the previous one.
REQ-014 resp_data and resp_err SHALL hold their values from RESPOND until the next latch.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 A req_valid[g] deassertion after acceptance SHALL not abort the job.

Reset
REQ-017 On reset=0 at a clk edge: state IDLE; req_ready, resp_valid, eng_start, eng_done_ack, busy, resp_err = 0; resp_data, eng_a = 0; last_grant = NREQ-1 (requester 0 has first priority); watchdog = 0.
REQ-018 Reset mid-job SHALL abandon the job without issuing eng_done_ack or any response.

Configuration
REQ-019 Macro MAT_ARB_TIMEOUT_EN defined: a watchdog counts WAIT cycles; on reaching TIMEOUT_CYCLES without eng_done, go to RESPOND with resp_data=0 and resp_err=1; the counter clears on entering WAIT.
REQ-020 MAT_ARB_TIMEOUT_EN undefined: no counter; WAIT is unbounded; resp_err is tied 0.

Structure
REQ-021 A shared package SHALL hold the state encoding (IDLE=2'b00, LAUNCH=2'b01, WAIT=2'b10, RESPOND=2'b11), result width 64, and the default TIMEOUT_CYCLES.
REQ-022 The round-robin pick SHALL be a sub-module rr_pick (inputs request vector and last_grant; output grant index and any-valid).

Verification
REQ-023 After reset, req_valid=4'b0101 -> req_ready=4'b0001, eng_start one cycle later; after eng_done with eng_res=64'h11223344 -> resp_valid=4'b0001, resp_data=64'h11223344.
REQ-024 Continuous req_valid=4'b1111 -> grant order 0,1,2,3,0.
REQ-025 eng_done=1 asserted 13 cycles after eng_start -> eng_done_ack high exactly on that cycle; resp_ready held low 5 cycles -> resp_valid stays high and resp_data stays stable.
REQ-026 With MAT_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, eng_done never asserted -> RESPOND 64 cycles into WAIT with resp_err=1 and resp_data=0; without the macro -> FSM remains in WAIT.
REQ-027 reset=0 during WAIT -> next cycle all outputs are at reset values; then req_valid=4'b1000 -> grant 3.
